// File: rtl/sub_step2_stage_if.sv
// Operand/result handshake bundle for the alignment-subtract stage.
// slave is the stage's view, master is the upstream/downstream environment.
interface sub_step2_stage_if #(
    parameter int LZC_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic             sign_shifted;
    logic [25:0]      frac_shifted;
    logic             sign_not_shifted;
    logic [25:0]      frac_not_shifted;
    logic [7:0]       exp_max;
    logic             cmp;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [26:0]      out_frac;
    logic [7:0]       out_exp;
    logic [LZC_W-1:0] out_lzc;
    logic             out_zero;

    modport slave (
        input  in_valid, sign_shifted, frac_shifted, sign_not_shifted,
               frac_not_shifted, exp_max, cmp, out_ready,
        output in_ready, out_valid, out_sign, out_frac, out_exp, out_lzc, out_zero
    );

    modport master (
        output in_valid, sign_shifted, frac_shifted, sign_not_shifted,
               frac_not_shifted, exp_max, cmp, out_ready,
        input  in_ready, out_valid, out_sign, out_frac, out_exp, out_lzc, out_zero
    );
endinterface

// File: rtl/sub_step2_stage.sv
// Two-stage signed-magnitude subtract X - Y of aligned fractions, with
// leading-zero count and zero detect; both stages advance in lockstep.
module sub_step2_stage #(
    parameter int LZC_W = 5
) (
    input  logic           CLK,
    input  logic           nRST,
    input  logic           flush,
    sub_step2_stage_if.slave bus
);
    logic             advance;
    logic             accept;

    logic [27:0]      val_shifted;
    logic [27:0]      val_not_shifted;
    logic [27:0]      x_val;
    logic [27:0]      y_val;
    logic [27:0]      diff;
    logic [27:0]      neg_diff;
    logic [26:0]      mag;

    logic             s1_valid;
    logic             s1_sign;
    logic [26:0]      s1_frac;
    logic [7:0]       s1_exp;

    logic [LZC_W-1:0] lzc_next;

    logic             s2_valid;
    logic             s2_sign;
    logic [26:0]      s2_frac;
    logic [7:0]       s2_exp;
    logic [LZC_W-1:0] s2_lzc;
    logic             s2_zero;

    assign advance      = bus.out_ready | ~s2_valid;
    assign accept       = bus.in_valid & advance;
    assign bus.in_ready = advance;

    // Both operands fit in 26 bits, so the 28-bit difference never overflows
    // and its magnitude always fits in 27 bits.
    always_comb begin
        val_shifted     = bus.sign_shifted ? -{2'b00, bus.frac_shifted}
                                           :  {2'b00, bus.frac_shifted};
        val_not_shifted = bus.sign_not_shifted ? -{2'b00, bus.frac_not_shifted}
                                               :  {2'b00, bus.frac_not_shifted};
        x_val    = bus.cmp ? val_shifted : val_not_shifted;
        y_val    = bus.cmp ? val_not_shifted : val_shifted;
        diff     = x_val - y_val;
        neg_diff = -diff;
        mag      = diff[27] ? neg_diff[26:0] : diff[26:0];
    end

    // Last set bit scanning upward wins, giving the count from bit 26.
    always_comb begin
        lzc_next = LZC_W'(27);
        for (int unsigned i = 0; i < 27; i++) begin
            if (s1_frac[i]) begin
                lzc_next = LZC_W'(26 - i);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_frac  <= '0;
            s1_exp   <= '0;
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_frac  <= '0;
            s2_exp   <= '0;
            s2_lzc   <= '0;
            s2_zero  <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= accept;
            s1_sign  <= diff[27];
            s1_frac  <= mag;
            s1_exp   <= bus.exp_max;
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_frac  <= s1_frac;
            s2_exp   <= s1_exp;
            s2_lzc   <= lzc_next;
            s2_zero  <= (s1_frac == '0);
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_sign  = s2_sign;
    assign bus.out_frac  = s2_frac;
    assign bus.out_exp   = s2_exp;
    assign bus.out_lzc   = s2_lzc;
    assign bus.out_zero  = s2_zero;
endmodule

// File: tb/tb_sub_step2_stage.sv
// Randomised scoreboard bench for sub_step2_stage with directed corner cases.
module tb_sub_step2_stage;
    typedef struct packed {
        logic        sign;
        logic [26:0] frac;
        logic [7:0]  exp;
        logic [4:0]  lzc;
        logic        zero;
    } res_t;

    logic clk;
    logic nrst;
    logic flush;
    int   tests;
    int   fails;
    bit   done;
    res_t q[$];

    sub_step2_stage_if #(.LZC_W(5)) bus();

    sub_step2_stage #(.LZC_W(5)) dut (
        .CLK   (clk),
        .nRST  (nrst),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed integer arithmetic on the operand values.
    function automatic res_t model(input logic sns, input logic [25:0] fns,
                                   input logic ss, input logic [25:0] fs,
                                   input logic [7:0] e, input logic c);
        res_t   r;
        longint u, s, x, y, d, m;
        int     bl;
        u = longint'(fns);
        s = longint'(fs);
        if (sns) u = -u;
        if (ss)  s = -s;
        x = c ? s : u;
        y = c ? u : s;
        d = x - y;
        m = (d < 0) ? -d : d;
        bl = 0;
        while ((m >> bl) != 0) bl++;
        r.sign = (d < 0);
        r.frac = m[26:0];
        r.exp  = e;
        r.zero = (m == 0);
        r.lzc  = 5'(27 - bl);
        return r;
    endfunction

    // Monitor / scoreboard: samples mid-low-phase, ahead of the next rising edge.
    initial begin : monitor
        res_t held;
        res_t cur;
        res_t e;
        bit   stall;
        stall = 0;
        held  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (done) break;
            if (!nrst) begin
                q.delete();
                stall = 0;
                continue;
            end
            cur = '{bus.out_sign, bus.out_frac, bus.out_exp, bus.out_lzc, bus.out_zero};
            check("in_ready", 64'(bus.in_ready), 64'(bus.out_ready || !bus.out_valid));
            if (stall) begin
                check("stall_valid", 64'(bus.out_valid), 64'd1);
                check("stall_data", 64'(cur), 64'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("out_sign", 64'(cur.sign), 64'(e.sign));
                    check("out_frac", 64'(cur.frac), 64'(e.frac));
                    check("out_exp",  64'(cur.exp),  64'(e.exp));
                    check("out_lzc",  64'(cur.lzc),  64'(e.lzc));
                    check("out_zero", 64'(cur.zero), 64'(e.zero));
                end
            end
            stall = bus.out_valid && !bus.out_ready && !flush;
            held  = cur;
            if (bus.in_valid && bus.in_ready && !flush)
                q.push_back(model(bus.sign_not_shifted, bus.frac_not_shifted,
                                  bus.sign_shifted, bus.frac_shifted,
                                  bus.exp_max, bus.cmp));
            if (flush) q.delete();
        end
    end

    task automatic send(input logic sns, input logic [25:0] fns, input logic ss,
                        input logic [25:0] fs, input logic [7:0] e, input logic c);
        int n;
        @(negedge clk);
        bus.sign_not_shifted = sns;
        bus.frac_not_shifted = fns;
        bus.sign_shifted     = ss;
        bus.frac_shifted     = fs;
        bus.exp_max          = e;
        bus.cmp              = c;
        bus.in_valid         = 1'b1;
        #1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_frac"},  64'(bus.out_frac),  64'd0);
        check({tag, "_sign"},  64'(bus.out_sign),  64'd0);
        check({tag, "_exp"},   64'(bus.out_exp),   64'd0);
        check({tag, "_lzc"},   64'(bus.out_lzc),   64'd0);
        check({tag, "_zero"},  64'(bus.out_zero),  64'd0);
    endtask

    task automatic directed(input logic sns, input logic [25:0] fns, input logic ss,
                            input logic [25:0] fs, input logic c, input string tag,
                            input logic [26:0] x_frac, input logic x_sign,
                            input logic [4:0] x_lzc, input logic x_zero);
        bus.out_ready = 1'b1;
        send(sns, fns, ss, fs, 8'd128, c);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_frac"},  64'(bus.out_frac),  64'(x_frac));
        check({tag, "_sign"},  64'(bus.out_sign),  64'(x_sign));
        check({tag, "_lzc"},   64'(bus.out_lzc),   64'(x_lzc));
        check({tag, "_exp"},   64'(bus.out_exp),   64'd128);
        check({tag, "_zero"},  64'(bus.out_zero),  64'(x_zero));
    endtask

    initial begin : driver
        tests = 0;
        fails = 0;
        done  = 0;
        nrst  = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.sign_shifted = 1'b0;
        bus.frac_shifted = '0;
        bus.sign_not_shifted = 1'b0;
        bus.frac_not_shifted = '0;
        bus.exp_max = '0;
        bus.cmp = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        #1;
        check("ready_after_reset", 64'(bus.in_ready), 64'd1);

        directed(1'b0, 26'h3000000, 1'b0, 26'h1000000, 1'b0, "three_minus_one",
                 27'h2000000, 1'b0, 5'd1, 1'b0);
        directed(1'b0, 26'h3000000, 1'b0, 26'h1000000, 1'b1, "one_minus_three",
                 27'h2000000, 1'b1, 5'd1, 1'b0);
        directed(1'b0, 26'h2000000, 1'b1, 26'h2000000, 1'b0, "one_minus_neg_one",
                 27'h4000000, 1'b0, 5'd0, 1'b0);
        directed(1'b0, 26'h2000000, 1'b0, 26'h2000000, 1'b0, "equal_zero",
                 27'h0, 1'b0, 5'd27, 1'b1);
        directed(1'b1, 26'h2000000, 1'b1, 26'h2000000, 1'b1, "equal_neg_zero",
                 27'h0, 1'b0, 5'd27, 1'b1);

        // Backpressure: fill both stages, third bundle must wait.
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(1'b0, 26'h1234567, 1'b1, 26'h0abcdef, 8'd10, 1'b0);
        send(1'b1, 26'h0000001, 1'b0, 26'h0000003, 8'd11, 1'b1);
        @(negedge clk);
        bus.frac_not_shifted = 26'h3ffffff;
        bus.frac_shifted     = 26'h0000001;
        bus.exp_max          = 8'd12;
        bus.in_valid         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("full_in_ready", 64'(bus.in_ready), 64'd0);
            check("full_out_valid", 64'(bus.out_valid), 64'd1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Flush with both stages full; the flush-cycle input is dropped.
        bus.out_ready = 1'b0;
        send(1'b0, 26'h0111111, 1'b0, 26'h0222222, 8'd20, 1'b0);
        send(1'b0, 26'h0333333, 1'b1, 26'h0444444, 8'd21, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("flush_dropped", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset mid-stream.
        bus.out_ready = 1'b0;
        send(1'b1, 26'h1555555, 1'b0, 26'h0aaaaaa, 8'd30, 1'b0);
        send(1'b0, 26'h0f0f0f0, 1'b0, 26'h00f0f0f, 8'd31, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #3;
        nrst = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("post_reset_empty", 64'(bus.out_valid), 64'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            bus.in_valid         = ($urandom_range(0, 3) != 0);
            bus.out_ready        = ($urandom_range(0, 9) < 7);
            flush                = ($urandom_range(0, 49) == 0);
            bus.sign_not_shifted = $urandom_range(0, 1);
            bus.sign_shifted     = $urandom_range(0, 1);
            bus.frac_not_shifted = 26'($urandom);
            bus.frac_shifted     = ($urandom_range(0, 7) == 0) ? bus.frac_not_shifted
                                                               : 26'($urandom >> $urandom_range(0, 25));
            bus.exp_max          = 8'($urandom);
            bus.cmp              = $urandom_range(0, 1);
        end

        @(negedge clk);
        bus.in_valid  = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        done = 1;
        @(negedge clk);
        #3;
        check("drain_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
